// File: rtl/rvx_wb_bridge.sv
// +---------------------------------------------------------------------------+
// | rvx_wb_bridge: rvx_core native request/response port to a pipelined       |
// | Wishbone master, one outstanding transaction, registered responses.       |
// | Optional watchdog: define RVX_WB_BRIDGE_TIMEOUT_EN.                        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module rvx_wb_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = 32'hDEADBEEF
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic [ADDR_WIDTH-1:0]   rw_address,
  input  logic                    read_request,
  input  logic                    write_request,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strobe,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_response,
  output logic                    write_response,
  output logic                    bus_error,
  output logic                    core_cyc,
  output logic                    core_stb,
  output logic                    core_we,
  output logic [DATA_WIDTH/8-1:0] core_sel,
  output logic [ADDR_WIDTH-1:0]   core_addr,
  output logic [DATA_WIDTH-1:0]   core_data_out,
  input  logic [DATA_WIDTH-1:0]   core_data_in,
  input  logic                    core_ack,
  input  logic                    core_stall
);

  localparam int c_sel_w = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STROBE   = 2'd1,
    WAIT_ACK = 2'd2,
    RESPOND  = 2'd3
  } state_t;

  state_t state, state_next;

  logic                  r_cyc, r_stb, r_we, r_rd_resp, r_wr_resp;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [c_sel_w-1:0]    r_sel;

  logic w_busy, w_acked, w_timeout, w_start;

  assign w_busy  = (state == STROBE) || (state == WAIT_ACK);
  // An ack only counts once the strobe has been accepted (no stall).
  assign w_acked = ((state == STROBE) && !core_stall && core_ack) ||
                   ((state == WAIT_ACK) && core_ack);

`ifdef RVX_WB_BRIDGE_TIMEOUT_EN
  localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_tmo_cnt;
  logic               r_bus_err;

  assign w_timeout = w_busy && !w_acked && (r_tmo_cnt == c_cnt_last);

  always_ff @(posedge clk_core) begin
    if (rst_core || !w_busy || w_acked || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + c_cnt_w'(1);
    end
    if (rst_core) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
    end
  end

  assign bus_error = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_comb begin
    state_next = state;
    w_start    = 1'b0;
    case (state)
      IDLE: begin
        if (read_request || write_request) begin
          state_next = STROBE;
          w_start    = 1'b1;
        end
      end
      STROBE: begin
        if (w_acked || w_timeout) begin
          state_next = RESPOND;
        end else if (!core_stall) begin
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (w_acked || w_timeout) begin
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus and response outputs are decoded from the next state so they are flops.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state     <= IDLE;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_rd_resp <= 1'b0;
      r_wr_resp <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_sel     <= '0;
      r_rdata   <= '0;
    end else begin
      state     <= state_next;
      r_cyc     <= (state_next == STROBE) || (state_next == WAIT_ACK);
      r_stb     <= (state_next == STROBE);
      r_rd_resp <= (state_next == RESPOND) && !r_we;
      r_wr_resp <= (state_next == RESPOND) && r_we;
      if (w_start) begin
        // Write has priority; a held read is picked up on the next IDLE.
        r_we    <= write_request;
        r_addr  <= rw_address;
        r_wdata <= write_data;
        r_sel   <= write_request ? write_strobe : {c_sel_w{1'b1}};
      end
      if (!r_we && w_acked) begin
        r_rdata <= core_data_in;
      end else if (!r_we && w_timeout) begin
        r_rdata <= ERROR_DATA;
      end
    end
  end

  assign read_data      = r_rdata;
  assign read_response  = r_rd_resp;
  assign write_response = r_wr_resp;
  assign core_cyc       = r_cyc;
  assign core_stb       = r_stb;
  assign core_we        = r_we;
  assign core_sel       = r_sel;
  assign core_addr      = r_addr;
  assign core_data_out  = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_rvx_wb_bridge.sv
// +---------------------------------------------------------------------------+
// | tb_rvx_wb_bridge: self-checking bench for rvx_wb_bridge (vector table,    |
// | hand-written corner sequences, randomized transactions vs. a model).      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_rvx_wb_bridge;

  localparam int TO = 8;
`ifdef RVX_WB_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic [31:0] rw_address;
  logic        read_request, write_request;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic [31:0] read_data;
  logic        read_response, write_response, bus_error;
  logic        core_cyc, core_stb, core_we;
  logic [3:0]  core_sel;
  logic [31:0] core_addr, core_data_out, core_data_in;
  logic        core_ack, core_stall;

  always #5 clk_core = ~clk_core;

  rvx_wb_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO),
    .ERROR_DATA    (32'hDEADBEEF)
  ) dut (
    .clk_core      (clk_core),
    .rst_core      (rst_core),
    .rw_address    (rw_address),
    .read_request  (read_request),
    .write_request (write_request),
    .write_data    (write_data),
    .write_strobe  (write_strobe),
    .read_data     (read_data),
    .read_response (read_response),
    .write_response(write_response),
    .bus_error     (bus_error),
    .core_cyc      (core_cyc),
    .core_stb      (core_stb),
    .core_we       (core_we),
    .core_sel      (core_sel),
    .core_addr     (core_addr),
    .core_data_out (core_data_out),
    .core_data_in  (core_data_in),
    .core_ack      (core_ack),
    .core_stall    (core_stall)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_rdata;   // reference: last value the core should see on read_data

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  strb;
    int          stall;
    int          wt;
    int          lat;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " cyc"}, 32'(core_cyc), 32'd0);
    chk({tag, " stb"}, 32'(core_stb), 32'd0);
    chk({tag, " rresp"}, 32'(read_response), 32'd0);
    chk({tag, " wresp"}, 32'(write_response), 32'd0);
    chk({tag, " berr"}, 32'(bus_error), 32'd0);
  endtask

  // Called at a negedge; request is sampled at the next posedge (edge N).
  // Cycle c observes what is visible just before edge N+c.
  task automatic run_txn(input bit we, input bit both, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [3:0] strb, input int stall_n, input int wait_n,
                         input bit stray, input int exp_lat);
    int         b, beff, r, stb_n;
    bit         to;
    logic [3:0] sel_e;
    b     = stall_n + 1 + wait_n;            // cycles spent in strobe+wait phases
    to    = TO_EN && (b > TO);
    beff  = to ? TO : b;
    r     = (exp_lat > 0) ? exp_lat : beff + 1;
    stb_n = (stall_n + 1 < beff) ? stall_n + 1 : beff;
    sel_e = we ? strb : 4'hF;
    write_request = we;
    read_request  = !we || both;
    rw_address    = addr;
    write_data    = wdata;
    write_strobe  = strb;
    core_ack      = 1'b0;
    core_stall    = 1'b0;
    for (int c = 1; c <= r + 1; c++) begin
      @(negedge clk_core);
      chk("cyc", 32'(core_cyc), 32'(c <= beff));
      chk("stb", 32'(core_stb), 32'(c <= stb_n));
      chk("rresp", 32'(read_response), 32'(c == r && !we));
      chk("wresp", 32'(write_response), 32'(c == r && we));
      chk("berr", 32'(bus_error), 32'(c == r && to));
      if (c <= beff) begin
        chk("addr", core_addr, addr);
        chk("we", 32'(core_we), 32'(we));
        chk("sel", 32'(core_sel), 32'(sel_e));
        if (we) chk("dout", core_data_out, wdata);
      end
      if (c == r && !we) m_rdata = to ? 32'hDEADBEEF : rdata;
      if (c >= r) chk("rdata", read_data, m_rdata);
      core_stall   = (c <= stall_n);
      core_ack     = (c == b) || (stray && c == r);
      core_data_in = (c == b) ? rdata : $urandom;
      if (c == r) begin
        write_request = 1'b0;
        if (!both) read_request = 1'b0;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    rst_core = 1'b1; read_request = 1'b0; write_request = 1'b0;
    rw_address = '0; write_data = '0; write_strobe = '0;
    core_data_in = '0; core_ack = 1'b0; core_stall = 1'b0;
    m_rdata = '0;

    tbl[0] = '{1'b0, 32'h100, 32'h0,        32'h12345678, 4'h0,    0, 0, 2};
    tbl[1] = '{1'b1, 32'h200, 32'hA5A5A5A5, 32'h0,        4'b0011, 2, 3, 7};
    tbl[2] = '{1'b0, 32'h104, 32'h0,        32'hCAFEF00D, 4'h0,    1, 0, 3};
    tbl[3] = '{1'b1, 32'h208, 32'h01234567, 32'h0,        4'b1000, 0, 2, 4};
    tbl[4] = '{1'b0, 32'h10C, 32'h0,        32'h0BADC0DE, 4'h0,    0, 1, 3};
    tbl[5] = '{1'b1, 32'h20C, 32'hFFEE0011, 32'h0,        4'hF,    3, 0, 5};

    repeat (3) @(negedge clk_core);
    chk_quiet("reset");
    chk("reset rdata", read_data, 32'h0);
    chk("reset addr", core_addr, 32'h0);
    chk("reset sel", 32'(core_sel), 32'h0);
    chk("reset we", 32'(core_we), 32'h0);
    chk("reset dout", core_data_out, 32'h0);
    rst_core = 1'b0;

    for (int i = 0; i < 10; i++) begin
      core_ack     = i[0];
      core_data_in = $urandom;
      @(negedge clk_core);
      chk_quiet("idle");
      chk("idle rdata", read_data, 32'h0);
    end
    core_ack = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].we, 1'b0, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].strb,
              tbl[i].stall, tbl[i].wt, 1'b1, tbl[i].lat);
    end

    // Both requests high: write first, then the still-held read.
    run_txn(1'b1, 1'b1, 32'h400, 32'h5A5A0F0F, 32'h0, 4'b1100, 0, 0, 1'b0, 2);
    run_txn(1'b0, 1'b0, 32'h400, 32'h0, 32'h87654321, 4'h0, 1, 1, 1'b0, 4);

    // Reset while waiting for ack.
    read_request = 1'b1; rw_address = 32'h300; core_ack = 1'b0; core_stall = 1'b0;
    @(negedge clk_core);
    chk("rst seq stb", 32'(core_stb), 32'd1);
    @(negedge clk_core);
    chk("rst seq cyc", 32'(core_cyc), 32'd1);
    chk("rst seq wait stb", 32'(core_stb), 32'd0);
    rst_core = 1'b1;
    @(negedge clk_core);
    m_rdata = '0;
    chk_quiet("rst seq after");
    chk("rst seq rdata", read_data, m_rdata);
    rst_core = 1'b0; read_request = 1'b0; core_ack = 1'b1;
    @(negedge clk_core);
    chk_quiet("rst seq idle");
    run_txn(1'b0, 1'b0, 32'h304, 32'h0, 32'h13572468, 4'h0, 0, 0, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      rv = $urandom;
      run_txn(rv[0], 1'b0, $urandom, $urandom, $urandom, rv[7:4],
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rv[1], 0);
    end

`ifdef RVX_WB_BRIDGE_TIMEOUT_EN
    run_txn(1'b0, 1'b0, 32'h500, 32'h0, 32'h11111111, 4'h0, 1, 40, 1'b0, 0);
    run_txn(1'b1, 1'b0, 32'h504, 32'h22222222, 32'h0, 4'h3, 0, 40, 1'b0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
